// File: rtl/bsg_transpose_row_gather.sv
// bsg_transpose_row_gather: gathers els_p rows into a ping-pong matrix buffer
// feeding the transpose stage over a valid/yumi interface.
module bsg_transpose_row_gather #(
    parameter int width_p = 16,
    parameter int els_p = 16,
    localparam int lg_els_lp = $clog2(els_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       ready_o,
    output logic                       v_o,
    output logic [width_p*els_p-1:0]   data_o,
    input  logic                       yumi_i
);
    logic [width_p*els_p-1:0] bank_q [2];
    logic [width_p*els_p-1:0] bank_d [2];
    logic [lg_els_lp-1:0] wr_row_q, wr_row_d;
    logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [1:0] full_q, full_d;
    logic acc, yumi, last;

    assign ready_o = ~full_q[wr_bank_q];
    assign v_o = full_q[rd_bank_q];
    assign data_o = bank_q[rd_bank_q];

    // accept and yumi always target different banks, so full_d updates never collide
    always_comb begin
        acc = v_i & ready_o;
        yumi = yumi_i & v_o;
        last = wr_row_q == lg_els_lp'(els_p - 1);
        bank_d = bank_q;
        if (acc) bank_d[wr_bank_q][wr_row_q*width_p +: width_p] = data_i;
        wr_row_d = acc ? (last ? '0 : wr_row_q + lg_els_lp'(1)) : wr_row_q;
        wr_bank_d = wr_bank_q ^ (acc & last);
        rd_bank_d = rd_bank_q ^ yumi;
        full_d = full_q;
        if (yumi) full_d[rd_bank_q] = 1'b0;
        if (acc & last) full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            bank_q <= '{default: '0};
            wr_row_q <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q <= 2'b00;
        end else begin
            bank_q <= bank_d;
            wr_row_q <= wr_row_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q <= full_d;
        end
    end

    assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o)
        else $error("yumi_i asserted while v_o is low");
endmodule

// File: tb/tb_bsg_transpose_row_gather.sv
// tb_bsg_transpose_row_gather: directed checks of row gathering, backpressure,
// drain order, simultaneous complete/yumi, streaming and async reset.
module tb_bsg_transpose_row_gather;
    logic clk_i = 1'b0;
    logic reset_n_i = 1'b0;
    logic v_i = 1'b0;
    logic [15:0] data_i = '0;
    logic ready_o, v_o, yumi_i = 1'b0;
    logic [255:0] data_o;
    int total = 0;
    int passed = 0;

    bsg_transpose_row_gather dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i),
        .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got %h exp %h", tag, got, exp);
    endtask

    task automatic push(input logic [15:0] d);
        v_i = 1'b1;
        data_i = d;
        tick();
        v_i = 1'b0;
    endtask

    function automatic logic [255:0] mat(input logic [15:0] base);
        logic [255:0] m;
        for (int r = 0; r < 16; r++) m[r*16 +: 16] = base | 16'(r);
        return m;
    endfunction

    task automatic producer();
        for (int i = 0; i < 64; i++) begin
            chk("stream_ready", ready_o, 1'b1);
            v_i = 1'b1;
            data_i = 16'(((i / 16) + 1) << 12) | 16'(i % 16);
            tick();
        end
        v_i = 1'b0;
    endtask

    task automatic consumer();
        for (int m = 0; m < 4; m++) begin
            int n = 0;
            while (!v_o && n < 200) begin
                tick();
                n++;
            end
            chk("stream_v_timeout", v_o, 1'b1);
            repeat (3) tick();
            chk("stream_data", data_o, mat(16'((m + 1) << 12)));
            yumi_i = v_o;
            tick();
            yumi_i = 1'b0;
        end
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_v", v_o, 1'b0);
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_data", data_o, '0);
        reset_n_i = 1'b1;
        tick();
        for (int r = 0; r < 16; r++) begin
            if (r == 15) chk("fill_v_pre", v_o, 1'b0);
            push(16'hA500 | 16'(r));
        end
        chk("fill_v", v_o, 1'b1);
        chk("fill_row0", data_o[15:0], 16'hA500);
        chk("fill_row15", data_o[255:240], 16'hA50F);
        chk("fill_ready", ready_o, 1'b1);
        for (int r = 0; r < 16; r++) begin
            if (r == 15) chk("bp_ready_pre", ready_o, 1'b1);
            push(16'hB600 | 16'(r));
        end
        chk("bp_ready", ready_o, 1'b0);
        v_i = 1'b1;
        data_i = 16'hC7C7;
        repeat (2) tick();
        v_i = 1'b0;
        chk("bp_ready_hold", ready_o, 1'b0);
        chk("bp_v", v_o, 1'b1);
        chk("bp_data", data_o, mat(16'hA500));
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        chk("drain_v1", v_o, 1'b1);
        chk("drain_data1", data_o, mat(16'hB600));
        chk("drain_ready1", ready_o, 1'b1);
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        chk("drain_v2", v_o, 1'b0);
        chk("drain_ready2", ready_o, 1'b1);
        for (int r = 0; r < 16; r++) push(16'hC000 | 16'(r));
        for (int r = 0; r < 16; r++) begin
            yumi_i = (r == 15);
            push(16'hD000 | 16'(r));
            yumi_i = 1'b0;
            chk("sim_v", v_o, 1'b1);
        end
        chk("sim_data", data_o, mat(16'hD000));
        chk("sim_ready", ready_o, 1'b1);
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        chk("sim_v_after", v_o, 1'b0);
        fork
            producer();
            consumer();
        join
        chk("stream_v_end", v_o, 1'b0);
        for (int r = 0; r < 16; r++) push(16'h6600 | 16'(r));
        for (int r = 0; r < 7; r++) push(16'h7700 | 16'(r));
        chk("ar_v_pre", v_o, 1'b1);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("ar_v", v_o, 1'b0);
        chk("ar_ready", ready_o, 1'b1);
        chk("ar_data", data_o, '0);
        tick();
        reset_n_i = 1'b1;
        for (int r = 0; r < 16; r++) push(16'hF000 | 16'(r));
        chk("ar_new_v", v_o, 1'b1);
        chk("ar_new_data", data_o, mat(16'hF000));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
